// File: rtl/sam_lite.sv
// sam_lite: synchronous MC6883 SAM subset for the CoCo2 core.
// E/Q phase clocks, SAM control register, S decode and VDG addressing.
module sam_lite #(
  parameter int HALF_PERIOD = 32,
  parameter int ROW_BYTES   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic        vdg_da0,
  input  logic        vdg_hs_n,
  input  logic        vdg_fs_n,
  output logic        E,
  output logic        Q,
  output logic [2:0]  s_sel,
  output logic [15:0] video_addr,
  output logic [2:0]  sam_v,
  output logic [6:0]  sam_f
);

  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam int BW = $clog2(ROW_BYTES + 1);

  localparam logic [PW-1:0] PC_END = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] PC_Q1  = PW'(HALF_PERIOD / 2);
  localparam logic [PW-1:0] PC_H   = PW'(HALF_PERIOD);
  localparam logic [PW-1:0] PC_Q3  = PW'(3 * HALF_PERIOD / 2);
  localparam logic [BW-1:0] B_MAX  = BW'(ROW_BYTES);

  logic [PW-1:0] pc_q, pc_d;
  logic          e_q, e_d;
  logic          q_q, q_d;
  logic          erise_q, erise_d;

  always_comb begin
    pc_d = (pc_q == PC_END) ? '0 : pc_q + 1'b1;
    q_d  = q_q;
    e_d  = e_q;
    if (pc_q == '0 || pc_q == PC_H)
      q_d = ~q_q;
    if (pc_q == PC_Q1 || pc_q == PC_Q3)
      e_d = ~e_q;
    erise_d = e_d & ~e_q;
  end

  // Bits 10..15 accept writes but drive nothing, so they are not stored.
  logic [9:0] ctrl_q, ctrl_d;
  logic       reg_wr;

  assign reg_wr = erise_q & ~cpu_rw
                & (cpu_addr[15:5] == 11'b1111_1111_110);

  always_comb begin
    ctrl_d = ctrl_q;
    if (reg_wr && cpu_addr[4:1] < 4'd10)
      ctrl_d[cpu_addr[4:1]] = cpu_addr[0];
  end

  logic hi_page;
  assign hi_page = (cpu_addr[15:8] == 8'hFF);

  always_comb begin
    s_sel = 3'd0;
    unique case (1'b1)
      ~cpu_addr[15]:
        s_sel = 3'd0;
      cpu_addr[15:13] == 3'b100:
        s_sel = 3'd1;
      cpu_addr[15:13] == 3'b101:
        s_sel = 3'd2;
      cpu_addr[15:14] == 2'b11 && !hi_page:
        s_sel = 3'd3;
      hi_page && cpu_addr[7:5] == 3'd0:
        s_sel = 3'd4;
      hi_page && cpu_addr[7:5] == 3'd1:
        s_sel = 3'd5;
      hi_page && cpu_addr[7:5] == 3'd2:
        s_sel = 3'd6;
      hi_page && cpu_addr[7:5] >= 3'd3
        && cpu_addr[7:4] != 4'hF:
        s_sel = 3'd7;
      hi_page && cpu_addr[7:4] == 4'hF:
        s_sel = 3'd2;
    endcase
  end

  logic [15:0]   addr_q, addr_d;
  logic [15:0]   rs_q, rs_d;
  logic [3:0]    row_q, row_d;
  logic [BW-1:0] byte_q, byte_d;
  logic          da0_q, hs_q, fs_q;
  logic          fs_fall, hs_fall, da0_rise;
  logic [3:0]    rpt;

  assign fs_fall  = fs_q & ~vdg_fs_n;
  assign hs_fall  = hs_q & ~vdg_hs_n;
  assign da0_rise = ~da0_q & vdg_da0;

  always_comb begin
    unique case (ctrl_q[2:0])
      3'd0:       rpt = 4'd12;
      3'd1, 3'd2: rpt = 4'd3;
      3'd3, 3'd4: rpt = 4'd2;
      default:    rpt = 4'd1;
    endcase
  end

  // One event per clk: field sync beats line sync beats a byte fetch.
  always_comb begin
    addr_d = addr_q;
    rs_d   = rs_q;
    row_d  = row_q;
    byte_d = byte_q;
    priority case (1'b1)
      fs_fall: begin
        addr_d = {ctrl_q[9:3], 9'b0};
        rs_d   = {ctrl_q[9:3], 9'b0};
        row_d  = '0;
        byte_d = '0;
      end
      hs_fall: begin
        byte_d = '0;
        if (({1'b0, row_q} + 5'd1) < {1'b0, rpt}) begin
          row_d  = row_q + 4'd1;
          addr_d = rs_q;
        end else begin
          row_d = '0;
          rs_d  = addr_q;
        end
      end
      da0_rise: begin
        if (byte_q < B_MAX) begin
          addr_d = addr_q + 16'd1;
          byte_d = byte_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      e_q     <= 1'b0;
      q_q     <= 1'b0;
      erise_q <= 1'b0;
      ctrl_q  <= '0;
      addr_q  <= '0;
      rs_q    <= '0;
      row_q   <= '0;
      byte_q  <= '0;
      da0_q   <= 1'b1;
      hs_q    <= 1'b1;
      fs_q    <= 1'b1;
    end else begin
      pc_q    <= pc_d;
      e_q     <= e_d;
      q_q     <= q_d;
      erise_q <= erise_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      rs_q    <= rs_d;
      row_q   <= row_d;
      byte_q  <= byte_d;
      da0_q   <= vdg_da0;
      hs_q    <= vdg_hs_n;
      fs_q    <= vdg_fs_n;
    end
  end

  assign E          = e_q;
  assign Q          = q_q;
  assign video_addr = addr_q;
  assign sam_v      = ctrl_q[2:0];
  assign sam_f      = ctrl_q[9:3];

endmodule

// File: tb/tb_sam_lite.sv
// tb_sam_lite: vector table, directed frames and a random
// VDG stream checked against an address-arithmetic model.
module tb_sam_lite;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic        vdg_da0, vdg_hs_n, vdg_fs_n;
  logic        E, Q;
  logic [2:0]  s_sel;
  logic [15:0] video_addr;
  logic [2:0]  sam_v;
  logic [6:0]  sam_f;

  always #5 clk = ~clk;

  sam_lite dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
    .vdg_da0(vdg_da0), .vdg_hs_n(vdg_hs_n),
    .vdg_fs_n(vdg_fs_n),
    .E(E), .Q(Q), .s_sel(s_sel),
    .video_addr(video_addr),
    .sam_v(sam_v), .sam_f(sam_f)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Model: address is always row start plus bytes fetched.
  logic [15:0] m_reg;
  logic [15:0] m_rs;
  int          m_line;
  int          m_bytes;
  logic        m_pda0, m_phs, m_pfs;
  int          rtab[8] = '{12, 3, 3, 2, 2, 1, 1, 1};

  task automatic model_reset();
    m_reg   = '0;
    m_rs    = '0;
    m_line  = 0;
    m_bytes = 0;
    m_pda0  = 1'b1;
    m_phs   = 1'b1;
    m_pfs   = 1'b1;
  endtask

  function automatic logic [2:0] ref_sel(input logic [15:0] a);
    if (a <= 16'h7FFF) return 3'd0;
    if (a <= 16'h9FFF) return 3'd1;
    if (a <= 16'hBFFF) return 3'd2;
    if (a <= 16'hFEFF) return 3'd3;
    if (a <= 16'hFF1F) return 3'd4;
    if (a <= 16'hFF3F) return 3'd5;
    if (a <= 16'hFF5F) return 3'd6;
    if (a <= 16'hFFEF) return 3'd7;
    return 3'd2;
  endfunction

  task automatic step(input logic da0,
                      input logic hs_n,
                      input logic fs_n);
    logic        fsf, hsf, dar;
    logic [15:0] exp_addr;
    vdg_da0  = da0;
    vdg_hs_n = hs_n;
    vdg_fs_n = fs_n;
    fsf = m_pfs & ~fs_n;
    hsf = m_phs & ~hs_n;
    dar = ~m_pda0 & da0;
    if (fsf) begin
      m_rs    = {m_reg[9:3], 9'b0};
      m_line  = 0;
      m_bytes = 0;
    end else if (hsf) begin
      if (m_line + 1 < rtab[m_reg[2:0]]) begin
        m_line++;
      end else begin
        m_line = 0;
        m_rs   = m_rs + 16'(m_bytes);
      end
      m_bytes = 0;
    end else if (dar) begin
      if (m_bytes < 32) m_bytes++;
    end
    m_pda0 = da0;
    m_phs  = hs_n;
    m_pfs  = fs_n;
    @(posedge clk);
    #1;
    exp_addr = m_rs + 16'(m_bytes);
    check("video_addr", video_addr, exp_addr);
  endtask

  task automatic da0_pulse();
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
  endtask

  task automatic hs_pulse();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
  endtask

  task automatic fs_pulse();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
  endtask

  task automatic cpu_cycle(input logic [15:0] a,
                           input logic rw);
    cpu_addr = a;
    cpu_rw   = rw;
    repeat (66) @(posedge clk);
    #1;
    cpu_rw   = 1'b1;
    cpu_addr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    if (!rw && a >= 16'hFFC0 && a <= 16'hFFDF)
      m_reg[a[4:1]] = a[0];
    check("sam_v", sam_v, m_reg[2:0]);
    check("sam_f", sam_f, m_reg[9:3]);
  endtask

  task automatic set_fv(input logic [6:0] f,
                        input logic [2:0] v);
    logic [9:0] val;
    val = {f, v};
    for (int b = 0; b < 10; b++)
      cpu_cycle(16'hFFC0 + 16'(2 * b) + 16'(val[b]), 1'b0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [2:0]  s;
  } sel_vec_t;

  sel_vec_t tv[20];

  initial begin
    #50ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic exp_q, exp_e;
    logic [15:0] ra;

    tv[0]  = '{16'h0000, 3'd0};
    tv[1]  = '{16'h7FFF, 3'd0};
    tv[2]  = '{16'h8000, 3'd1};
    tv[3]  = '{16'h9FFF, 3'd1};
    tv[4]  = '{16'hA000, 3'd2};
    tv[5]  = '{16'hBFFF, 3'd2};
    tv[6]  = '{16'hC000, 3'd3};
    tv[7]  = '{16'hFEFF, 3'd3};
    tv[8]  = '{16'hFF00, 3'd4};
    tv[9]  = '{16'hFF1F, 3'd4};
    tv[10] = '{16'hFF22, 3'd5};
    tv[11] = '{16'hFF3F, 3'd5};
    tv[12] = '{16'hFF40, 3'd6};
    tv[13] = '{16'hFF5F, 3'd6};
    tv[14] = '{16'hFF60, 3'd7};
    tv[15] = '{16'hFFC0, 3'd7};
    tv[16] = '{16'hFFEF, 3'd7};
    tv[17] = '{16'hFFF0, 3'd2};
    tv[18] = '{16'hFFFE, 3'd2};
    tv[19] = '{16'hFFFF, 3'd2};

    reset    = 1'b0;
    cpu_addr = 16'h0000;
    cpu_rw   = 1'b1;
    vdg_da0  = 1'b1;
    vdg_hs_n = 1'b1;
    vdg_fs_n = 1'b1;
    model_reset();
    #1;
    check("rst_video_addr", video_addr, 16'h0000);
    check("rst_sam_v", sam_v, 3'd0);
    check("rst_sam_f", sam_f, 7'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_E", E, 1'b0);
      check("rst_Q", Q, 1'b0);
    end

    reset = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      @(posedge clk);
      #1;
      exp_q = (((k - 1) / 32) % 2) == 0;
      exp_e = (k >= 17) && ((((k - 17) / 32) % 2) == 0);
      check("phase_Q", Q, exp_q);
      check("phase_E", E, exp_e);
    end

    foreach (tv[i]) begin
      cpu_addr = tv[i].a;
      #1;
      check("s_sel_vec", s_sel, tv[i].s);
    end
    repeat (200) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ra[15:8] = 8'hFF;
      cpu_addr = ra;
      #1;
      check("s_sel_rand", s_sel, ref_sel(ra));
    end
    cpu_addr = 16'h0000;
    @(posedge clk);
    #1;

    cpu_cycle(16'hFFC7, 1'b0);
    cpu_cycle(16'hFFC9, 1'b0);
    cpu_cycle(16'hFFCB, 1'b0);
    check("ctrl_f07", sam_f, 7'h07);
    check("ctrl_v0", sam_v, 3'd0);
    cpu_cycle(16'hFFC6, 1'b0);
    check("ctrl_f06", sam_f, 7'h06);
    cpu_cycle(16'hFFC9, 1'b1);
    cpu_cycle(16'hFFE1, 1'b0);
    cpu_cycle(16'hFFBF, 1'b0);
    cpu_cycle(16'hFFDF, 1'b0);
    check("ctrl_nowrite", {sam_f, sam_v}, {7'h06, 3'd0});
    cpu_cycle(16'hFFCA, 1'b0);
    check("ctrl_f02", sam_f, 7'h02);

    fs_pulse();
    check("fs_base", video_addr, 16'h0400);
    repeat (32) da0_pulse();
    check("row_full", video_addr, 16'h0420);
    da0_pulse();
    check("row_sat", video_addr, 16'h0420);
    for (int h = 1; h <= 12; h++) begin
      hs_pulse();
      if (h < 12) begin
        check("v0_repeat", video_addr, 16'h0400);
        repeat (32) da0_pulse();
      end else begin
        check("v0_advance", video_addr, 16'h0420);
      end
    end
    repeat (3) da0_pulse();
    check("v0_next_row", video_addr, 16'h0423);

    cpu_cycle(16'hFFC1, 1'b0);
    cpu_cycle(16'hFFC3, 1'b0);
    cpu_cycle(16'hFFC5, 1'b0);
    check("v7_set", sam_v, 3'd7);
    fs_pulse();
    repeat (32) da0_pulse();
    hs_pulse();
    check("v7_advance", video_addr, 16'h0420);
    repeat (5) da0_pulse();
    check("v7_bytes", video_addr, 16'h0425);
    step(1'b1, 1'b0, 1'b0);
    check("fs_hs_same", video_addr, 16'h0400);
    step(1'b1, 1'b1, 1'b1);

    cpu_cycle(16'hFFC2, 1'b0);
    cpu_cycle(16'hFFC4, 1'b0);
    check("v1_set", sam_v, 3'd1);
    for (int h = 1; h <= 3; h++) begin
      repeat (4) da0_pulse();
      hs_pulse();
      check("v1_row", video_addr,
            (h < 3) ? 16'h0400 : 16'h0404);
    end

    set_fv(7'h7F, 3'd7);
    fs_pulse();
    check("wrap_base", video_addr, 16'hFE00);
    for (int r = 0; r < 16; r++) begin
      repeat (32) da0_pulse();
      hs_pulse();
    end
    check("wrap_zero", video_addr, 16'h0000);

    for (int blk = 0; blk < 4; blk++) begin
      set_fv(7'($urandom), 3'($urandom));
      repeat (800)
        step(1'($urandom_range(0, 1)),
             $urandom_range(0, 29) != 0,
             $urandom_range(0, 399) != 0);
      step(1'b1, 1'b1, 1'b1);
      if (blk == 1) begin
        #2;
        reset = 1'b0;
        #2;
        check("midrst_addr", video_addr, 16'h0000);
        check("midrst_f", sam_f, 7'd0);
        check("midrst_v", sam_v, 3'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
